// File: rtl/lc3_pkg.sv
// Shared LC-3 control-transfer definitions: opcodes, branch FSM states and
// offset sign extension.
package lc3_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b1100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // Width 9 takes imm[8:0]; any other width is treated as the 11-bit form.
    function automatic logic [15:0] sext(input logic [10:0] imm, input int unsigned width);
        logic [15:0] res;
        if (width == 9) begin
            res = {{7{imm[8]}}, imm[8:0]};
        end else begin
            res = {{5{imm[10]}}, imm};
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_ctrl_pc_target.sv
// Combinational target selection for BR, JMP/RET and JSR/JSRR.
module pc_target
    import lc3_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [15:0] pc,
    input  logic [15:0] sr1,
    output logic [15:0] target
);

    always_comb begin
        target = sr1;
        case (ir[15:12])
            OP_BR:   target = pc + sext({2'b00, ir[8:0]}, 9);
            OP_JSR:  if (ir[11]) target = pc + sext(ir[10:0], 11);
            default: target = sr1;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// LC-3 control-transfer unit: captures an instruction on start, evaluates BEN
// and the target, then commits the PC load and optional R7 link write.
//
// state  | meaning
// IDLE   | waiting for start; captures ir, nzp, pc, sr1 when it arrives
// EVAL   | computes ben/taken/target from captured values, registers strobes
// COMMIT | done, ld_pc, r7_we valid for this cycle; returns to IDLE
module branch_ctrl
    import lc3_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    input  logic [15:0] pc,
    input  logic [15:0] sr1,
    output logic        busy,
    output logic        ben,
    output logic [15:0] pc_next,
    output logic        ld_pc,
    output logic        r7_we,
    output logic [15:0] r7_data,
    output logic        done
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [2:0]  nzp_q, nzp_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] sr1_q, sr1_d;
    logic        ben_q, ben_d;
    logic [15:0] pc_next_q, pc_next_d;
    logic        ld_pc_q, ld_pc_d;
    logic        r7_we_q, r7_we_d;
    logic [15:0] r7_data_q, r7_data_d;
    logic        done_q, done_d;

    logic [15:0] target;
    logic        br_ben;
    logic        taken;
    logic        link;

    pc_target u_pc_target (
        .ir     (ir_q),
        .pc     (pc_q),
        .sr1    (sr1_q),
        .target (target)
    );

    assign br_ben = |(ir_q[11:9] & nzp_q);

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        nzp_d     = nzp_q;
        pc_d      = pc_q;
        sr1_d     = sr1_q;
        ben_d     = ben_q;
        pc_next_d = pc_next_q;
        r7_data_d = r7_data_q;
        ld_pc_d   = 1'b0;
        r7_we_d   = 1'b0;
        done_d    = 1'b0;
        taken     = 1'b0;
        link      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ir_d    = ir;
                    nzp_d   = {n, z, p};
                    pc_d    = pc;
                    sr1_d   = sr1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                ben_d = 1'b0;
                case (ir_q[15:12])
                    OP_BR: begin
                        ben_d = br_ben;
                        taken = br_ben;
                    end
                    OP_JMP: taken = 1'b1;
                    OP_JSR: begin
                        taken = 1'b1;
                        link  = 1'b1;
                    end
                    default: taken = 1'b0;
                endcase
                pc_next_d = target;
                ld_pc_d   = taken;
                r7_we_d   = link;
                // Link value is the captured PC, so JSRR R7 still sees the old R7 in sr1_q.
                if (link) r7_data_d = pc_q;
                done_d    = 1'b1;
                state_d   = COMMIT;
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ir_q      <= 16'h0000;
            nzp_q     <= 3'b000;
            pc_q      <= 16'h0000;
            sr1_q     <= 16'h0000;
            ben_q     <= 1'b0;
            pc_next_q <= 16'h0000;
            ld_pc_q   <= 1'b0;
            r7_we_q   <= 1'b0;
            r7_data_q <= 16'h0000;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            nzp_q     <= nzp_d;
            pc_q      <= pc_d;
            sr1_q     <= sr1_d;
            ben_q     <= ben_d;
            pc_next_q <= pc_next_d;
            ld_pc_q   <= ld_pc_d;
            r7_we_q   <= r7_we_d;
            r7_data_q <= r7_data_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign ben     = ben_q;
    assign pc_next = pc_next_q;
    assign ld_pc   = ld_pc_q;
    assign r7_we   = r7_we_q;
    assign r7_data = r7_data_q;
    assign done    = done_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed cases plus randomized
// instructions compared against an arithmetic reference model.
module tb_branch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] ir;
    logic        n;
    logic        z;
    logic        p;
    logic [15:0] pc;
    logic [15:0] sr1;
    logic        busy;
    logic        ben;
    logic [15:0] pc_next;
    logic        ld_pc;
    logic        r7_we;
    logic [15:0] r7_data;
    logic        done;

    int checks   = 0;
    int failures = 0;

    branch_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ir      (ir),
        .n       (n),
        .z       (z),
        .p       (p),
        .pc      (pc),
        .sr1     (sr1),
        .busy    (busy),
        .ben     (ben),
        .pc_next (pc_next),
        .ld_pc   (ld_pc),
        .r7_we   (r7_we),
        .r7_data (r7_data),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: LC-3 control-transfer semantics with plain integer arithmetic.
    task automatic ref_model(input logic [15:0] i_ir, input logic [2:0] i_nzp,
                             input logic [15:0] i_pc, input logic [15:0] i_sr1,
                             output logic e_ben, output logic e_taken,
                             output logic e_link, output logic [15:0] e_tgt);
        int op;
        int off;
        op      = int'(i_ir[15:12]);
        e_ben   = 1'b0;
        e_taken = 1'b0;
        e_link  = 1'b0;
        e_tgt   = 16'h0000;
        if (op == 0) begin
            e_ben   = (i_ir[11] && i_nzp[2]) || (i_ir[10] && i_nzp[1]) || (i_ir[9] && i_nzp[0]);
            e_taken = e_ben;
            off     = int'(i_ir[8:0]);
            if (off >= 256) off = off - 512;
            e_tgt   = 16'((int'(i_pc) + off + 65536) % 65536);
        end else if (op == 12) begin
            e_taken = 1'b1;
            e_tgt   = i_sr1;
        end else if (op == 4) begin
            e_taken = 1'b1;
            e_link  = 1'b1;
            if (i_ir[11]) begin
                off = int'(i_ir[10:0]);
                if (off >= 1024) off = off - 2048;
                e_tgt = 16'((int'(i_pc) + off + 65536) % 65536);
            end else begin
                e_tgt = i_sr1;
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [15:0] i_ir, input logic [2:0] i_nzp,
                         input logic [15:0] i_pc, input logic [15:0] i_sr1);
        logic        e_ben;
        logic        e_taken;
        logic        e_link;
        logic [15:0] e_tgt;
        ref_model(i_ir, i_nzp, i_pc, i_sr1, e_ben, e_taken, e_link, e_tgt);
        @(negedge clk);
        ir = i_ir; {n, z, p} = i_nzp; pc = i_pc; sr1 = i_sr1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Live inputs must not influence the evaluation.
        ir = 16'($urandom); pc = 16'($urandom); sr1 = 16'($urandom); {n, z, p} = 3'($urandom);
        chk({tag, ".eval_busy"}, 16'(busy), 16'd1);
        chk({tag, ".eval_done"}, 16'(done), 16'd0);
        @(posedge clk); #1;
        chk({tag, ".done"}, 16'(done), 16'd1);
        chk({tag, ".ld_pc"}, 16'(ld_pc), 16'(e_taken));
        chk({tag, ".r7_we"}, 16'(r7_we), 16'(e_link));
        chk({tag, ".ben"}, 16'(ben), 16'(e_ben));
        if (e_taken) chk({tag, ".pc_next"}, pc_next, e_tgt);
        if (e_link)  chk({tag, ".r7_data"}, r7_data, i_pc);
        @(posedge clk); #1;
        chk({tag, ".post_done"}, 16'(done), 16'd0);
        chk({tag, ".post_ld_pc"}, 16'(ld_pc), 16'd0);
        chk({tag, ".post_r7_we"}, 16'(r7_we), 16'd0);
        chk({tag, ".post_busy"}, 16'(busy), 16'd0);
        chk({tag, ".ben_hold"}, 16'(ben), 16'(e_ben));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".busy"}, 16'(busy), 16'd0);
        chk({tag, ".ben"}, 16'(ben), 16'd0);
        chk({tag, ".ld_pc"}, 16'(ld_pc), 16'd0);
        chk({tag, ".r7_we"}, 16'(r7_we), 16'd0);
        chk({tag, ".done"}, 16'(done), 16'd0);
        chk({tag, ".pc_next"}, pc_next, 16'h0000);
        chk({tag, ".r7_data"}, r7_data, 16'h0000);
    endtask

    initial begin
        int          done_cnt;
        logic [3:0]  opc;
        logic [3:0]  op_tab [8];
        op_tab = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'hC, 4'h1, 4'h5};

        rst_n = 1'b0; start = 1'b0; ir = 16'h0000; n = 1'b0; z = 1'b0; p = 1'b0;
        pc = 16'h0000; sr1 = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        do_op("br_taken", 16'h0A05, 3'b100, 16'h3001, 16'h0000);
        chk("br_taken.pc_val", pc_next, 16'h3006);
        chk("br_taken.ben_val", 16'(ben), 16'd1);
        do_op("br_not_taken", 16'h0405, 3'b001, 16'h3001, 16'h0000);
        chk("br_not_taken.ben_val", 16'(ben), 16'd0);
        do_op("br_nop", 16'h0000, 3'b010, 16'h3001, 16'h0000);
        do_op("wrap_neg", 16'h0FFF, 3'b010, 16'h0000, 16'h1234);
        chk("wrap_neg.pc_val", pc_next, 16'hFFFF);
        do_op("wrap_pos", 16'h0E01, 3'b001, 16'hFFFF, 16'h1234);
        chk("wrap_pos.pc_val", pc_next, 16'h0000);
        do_op("wrap_sign", 16'h0E01, 3'b100, 16'h7FFF, 16'h1234);
        chk("wrap_sign.pc_val", pc_next, 16'h8000);
        do_op("jsr", 16'h4FFE, 3'b000, 16'h3010, 16'h5555);
        chk("jsr.pc_val", pc_next, 16'h300E);
        chk("jsr.link_val", r7_data, 16'h3010);
        do_op("jsrr_r7", 16'h41C0, 3'b000, 16'h3020, 16'h4000);
        chk("jsrr_r7.pc_val", pc_next, 16'h4000);
        chk("jsrr_r7.link_val", r7_data, 16'h3020);
        do_op("ret", 16'hC1C0, 3'b000, 16'h3030, 16'h3011);
        chk("ret.pc_val", pc_next, 16'h3011);
        do_op("add", 16'h1021, 3'b111, 16'h3040, 16'h0001);

        // Second start during EVAL is dropped: exactly one done.
        @(negedge clk);
        ir = 16'h0A05; {n, z, p} = 3'b100; pc = 16'h3001; sr1 = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        ir = 16'h0E01; pc = 16'h2000;
        done_cnt = 0;
        @(posedge clk); #1;
        start = 1'b0;
        done_cnt += int'(done);
        chk("busy_start.pc_val", pc_next, 16'h3006);
        repeat (5) begin
            @(posedge clk); #1;
            done_cnt += int'(done);
        end
        chk("busy_start.done_count", 16'(done_cnt), 16'd1);

        // Reset during EVAL aborts the operation with no commit pulses.
        @(negedge clk);
        ir = 16'h4FFE; {n, z, p} = 3'b000; pc = 16'h3010; sr1 = 16'h0000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_reset_vals("abort");
        @(posedge clk); #1;
        chk("abort.late_done", 16'(done), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_reset", 16'h0A05, 3'b001, 16'h3001, 16'h0000);

        for (int k = 0; k < 150; k++) begin
            opc = op_tab[$urandom_range(0, 7)];
            do_op("rand", {opc, 12'($urandom)}, 3'($urandom), 16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
